// File: rtl/main_control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : main_control_pkg
//  Description : Shared opcode constants, ALU-control class encodings and the
//                bundled control-word type for the main control decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package main_control_pkg;

    // Instruction opcode field values, instruction bits [6:0]
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    // ALU-control class handed to the downstream ALU decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // Seven datapath control signals plus the illegal-opcode flag
    typedef struct packed {
        logic       branch;
        logic       memRead;
        logic       memtoReg;
        logic [1:0] aluOp;
        logic       memWrite;
        logic       aluSrc;
        logic       regWrite;
        logic       illegal;
    } ctrl_t;

    // Safe control word: nothing writes memory or the register file
    function automatic ctrl_t ctrlIllegal();
        ctrl_t c_word;
        c_word         = '0;
        c_word.illegal = 1'b1;
        return c_word;
    endfunction

endpackage : main_control_pkg
`default_nettype wire

// File: rtl/main_control_dec.sv
`default_nettype none
// ============================================================================
//  Module      : main_control_dec
//  Description : Purely combinational opcode-to-control-word decoder. Any
//                opcode not in the decoded set (including X/Z in simulation)
//                falls through to the safe illegal word.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_control_dec
    import main_control_pkg::*;
(
    input  logic [6:0] i_op,
    output ctrl_t      o_ctrl
);

    // Start from the safe word so unmatched or unknown opcodes can never write
    always_comb begin
        o_ctrl = ctrlIllegal();
        case (i_op)
            OP_RTYPE: begin
                o_ctrl.aluOp    = ALUOP_RTYPE;
                o_ctrl.regWrite = 1'b1;
                o_ctrl.illegal  = 1'b0;
            end
            OP_LOAD: begin
                o_ctrl.memRead  = 1'b1;
                o_ctrl.memtoReg = 1'b1;
                o_ctrl.aluOp    = ALUOP_ADD;
                o_ctrl.aluSrc   = 1'b1;
                o_ctrl.regWrite = 1'b1;
                o_ctrl.illegal  = 1'b0;
            end
            OP_STORE: begin
                // memtoReg is a don't-care for stores but is driven low
                o_ctrl.memtoReg = 1'b0;
                o_ctrl.aluOp    = ALUOP_ADD;
                o_ctrl.memWrite = 1'b1;
                o_ctrl.aluSrc   = 1'b1;
                o_ctrl.illegal  = 1'b0;
            end
            OP_BRANCH: begin
                o_ctrl.branch   = 1'b1;
                o_ctrl.aluOp    = ALUOP_SUB;
                o_ctrl.illegal  = 1'b0;
            end
            OP_ITYPE: begin
                o_ctrl.aluOp    = ALUOP_ITYPE;
                o_ctrl.aluSrc   = 1'b1;
                o_ctrl.regWrite = 1'b1;
                o_ctrl.illegal  = 1'b0;
            end
            default: begin
                o_ctrl = ctrlIllegal();
            end
        endcase
    end

endmodule : main_control_dec
`default_nettype wire

// File: rtl/main_control.sv
`default_nettype none
// ============================================================================
//  Module      : main_control
//  Description : Main control unit. Decodes the instruction opcode into the
//                datapath control signals, optionally through one output
//                register stage with asynchronous active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_control
    import main_control_pkg::*;
#(
    parameter int REG_OUT = 1
)(
    input  logic       clk,
    input  logic       rst_n,
    output logic       Branch,
    output logic       MemRead,
    output logic       MemtoReg,
    output logic [1:0] ALUop,
    output logic       MemWrite,
    output logic       ALUsrc,
    output logic       RegWrite,
    input  logic [6:0] OP,
    output logic       IllegalOp
);

    ctrl_t w_decCtrl;
    ctrl_t w_outCtrl;

    main_control_dec u_dec (
        .i_op   (OP),
        .o_ctrl (w_decCtrl)
    );

    generate
        if (REG_OUT != 0) begin : g_regOut
            ctrl_t r_ctrl;

            // One-cycle output register; reset clears every output, flag included
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ctrl <= '0;
                end else begin
                    r_ctrl <= w_decCtrl;
                end
            end

            assign w_outCtrl = r_ctrl;
        end else begin : g_combOut
            // Clock and reset have no function in the combinational build
            logic w_unusedClkRst;
            assign w_unusedClkRst = clk ^ rst_n;
            assign w_outCtrl      = w_decCtrl;
        end
    endgenerate

    // Unpack the control word onto the legacy port list
    assign Branch    = w_outCtrl.branch;
    assign MemRead   = w_outCtrl.memRead;
    assign MemtoReg  = w_outCtrl.memtoReg;
    assign ALUop     = w_outCtrl.aluOp;
    assign MemWrite  = w_outCtrl.memWrite;
    assign ALUsrc    = w_outCtrl.aluSrc;
    assign RegWrite  = w_outCtrl.regWrite;
    assign IllegalOp = w_outCtrl.illegal;

endmodule : main_control
`default_nettype wire

// File: tb/tb_main_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_control
//  Description : Self-checking bench for main_control, registered and
//                combinational builds side by side on a shared opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_control;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;

    logic       rBranch, rMemRead, rMemtoReg, rMemWrite, rAluSrc, rRegWrite, rIllegal;
    logic [1:0] rAluOp;
    logic       cBranch, cMemRead, cMemtoReg, cMemWrite, cAluSrc, cRegWrite, cIllegal;
    logic [1:0] cAluOp;

    int nChecks;
    int nFails;

    main_control #(.REG_OUT(1)) dutReg (
        .clk(clk), .rst_n(rst_n),
        .Branch(rBranch), .MemRead(rMemRead), .MemtoReg(rMemtoReg), .ALUop(rAluOp),
        .MemWrite(rMemWrite), .ALUsrc(rAluSrc), .RegWrite(rRegWrite),
        .OP(op), .IllegalOp(rIllegal)
    );

    main_control #(.REG_OUT(0)) dutComb (
        .clk(clk), .rst_n(rst_n),
        .Branch(cBranch), .MemRead(cMemRead), .MemtoReg(cMemtoReg), .ALUop(cAluOp),
        .MemWrite(cMemWrite), .ALUsrc(cAluSrc), .RegWrite(cRegWrite),
        .OP(op), .IllegalOp(cIllegal)
    );

    // Observed tuple {Branch,MemRead,MemtoReg,ALUop,MemWrite,ALUsrc,RegWrite,IllegalOp}
    wire [8:0] gotReg  = {rBranch, rMemRead, rMemtoReg, rAluOp, rMemWrite, rAluSrc, rRegWrite, rIllegal};
    wire [8:0] gotComb = {cBranch, cMemRead, cMemtoReg, cAluOp, cMemWrite, cAluSrc, cRegWrite, cIllegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a lookup of the five legal instruction classes
    typedef struct {
        logic [6:0] op;
        logic [8:0] ctl;
    } legal_t;
    legal_t legalTbl[5];

    function automatic logic [8:0] model(input logic [6:0] o);
        logic [8:0] res;
        res = 9'b0_0_0_00_0_0_0_1;
        for (int i = 0; i < 5; i++)
            if (legalTbl[i].op === o) res = legalTbl[i].ctl;
        return res;
    endfunction

    task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %b required %b (B/MR/MtR/ALU/MW/AS/RW/Ill)", name, got, exp);
        end
    endtask

    // Registered-output value currently expected from dutReg
    logic [8:0] expRegNow;

    // Drive op at the falling edge; comb follows at once, reg holds until the next rise
    task automatic applyOp(input string name, input logic [6:0] o, input logic [8:0] exp);
        @(negedge clk);
        op = o;
        #1;
        check({name, "/comb"}, gotComb, exp);
        check({name, "/hold"}, gotReg, expRegNow);
        @(posedge clk);
        #1;
        check({name, "/reg"}, gotReg, exp);
        expRegNow = exp;
    endtask

    typedef struct {
        logic [6:0] op;
        logic [8:0] exp;
        string      name;
    } vec_t;
    vec_t vecs[7];

    int         nIllegal;
    logic [6:0] rop;
    logic [8:0] e;

    initial begin
        nChecks = 0;
        nFails  = 0;
        legalTbl[0] = '{7'd51, 9'b0_0_0_10_0_0_1_0};
        legalTbl[1] = '{7'd3,  9'b0_1_1_00_0_1_1_0};
        legalTbl[2] = '{7'd35, 9'b0_0_0_00_1_1_0_0};
        legalTbl[3] = '{7'd99, 9'b1_0_0_01_0_0_0_0};
        legalTbl[4] = '{7'd19, 9'b0_0_0_11_0_1_1_0};

        vecs[0] = '{7'd51,       9'b0_0_0_10_0_0_1_0, "rtype"};
        vecs[1] = '{7'd3,        9'b0_1_1_00_0_1_1_0, "load"};
        vecs[2] = '{7'd35,       9'b0_0_0_00_1_1_0_0, "store"};
        vecs[3] = '{7'd99,       9'b1_0_0_01_0_0_0_0, "branch"};
        vecs[4] = '{7'd19,       9'b0_0_0_11_0_1_1_0, "itype"};
        vecs[5] = '{7'b0000000,  9'b0_0_0_00_0_0_0_1, "op00"};
        vecs[6] = '{7'b1111111,  9'b0_0_0_00_0_0_0_1, "op7f"};

        // Bring-up: run an illegal opcode so the register holds a nonzero word
        rst_n = 1'b1;
        op    = 7'd0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset", gotReg, 9'b0_0_0_00_0_0_0_1);

        // Asynchronous clear mid-cycle with an R-type decode in flight
        @(negedge clk);
        op = 7'd51;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async", gotReg, 9'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_ignores_clk", gotReg, 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_hold", gotReg, 9'b0);
        @(posedge clk);
        #1;
        check("reset_first_edge", gotReg, 9'b0_0_0_10_0_0_1_0);
        expRegNow = 9'b0_0_0_10_0_0_1_0;

        // Directed table, one opcode per cycle
        foreach (vecs[i]) applyOp(vecs[i].name, vecs[i].op, vecs[i].exp);

        // Unknown opcode must decode as illegal
        applyOp("opX", 7'bx, model(7'bx));

        // Combinational build reacts without any clock edge
        @(posedge clk);
        #1;
        op = 7'd3;
        #1;
        check("comb_no_edge", gotComb, 9'b0_1_1_00_0_1_1_0);
        check("reg_no_edge", gotReg, expRegNow);
        @(posedge clk);
        #1;
        expRegNow = model(7'd3);

        // Exhaustive sweep with safety invariants
        nIllegal = 0;
        for (int v = 0; v < 128; v++) begin
            rop = v[6:0];
            e   = model(rop);
            applyOp("sweep", rop, e);
            if (gotComb[0]) nIllegal++;
            nChecks++;
            if ((rMemRead && rMemWrite) || (cMemRead && cMemWrite) ||
                (rBranch && rRegWrite) || (cBranch && cRegWrite)) begin
                nFails++;
                $display("FAIL sweep_invariant op=%0d: got reg %b comb %b required no MR&MW, no B&RW",
                         v, gotReg, gotComb);
            end
        end
        nChecks++;
        if (nIllegal != 123) begin
            nFails++;
            $display("FAIL illegal_count: got %0d required 123", nIllegal);
        end

        // Randomized stream, biased toward legal opcodes
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 1) == 0) rop = legalTbl[$urandom_range(0, 4)].op;
            else                           rop = 7'($urandom_range(0, 127));
            applyOp("random", rop, model(rop));
        end

        // Reset in the middle of a random stream discards the decode
        @(negedge clk);
        op = 7'd99;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_midstream", gotReg, 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_midstream_reload", gotReg, 9'b1_0_0_01_0_0_0_0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule : tb_main_control
`default_nettype wire
